// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth sequential multiplier.
// No logic; imported by the step datapath and the top-level FSM.
// Carries no flow control of its own.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth op-codes, decoded from {Q[0], Q_-1}
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of M into A, then arithmetic shift of {A,Q,Q_-1}.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to register the result.
module booth_step
    import booth_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N:0]   a,
    input  logic [N-1:0] q,
    input  logic         q1,
    input  logic [N:0]   m,
    output logic [N:0]   a_nxt,
    output logic [N-1:0] q_nxt,
    output logic         q1_nxt
);

    logic [N:0] sum;

    // Add/sub wraps modulo 2^(N+1); the extra accumulator bit keeps -2^(N-1) exact
    always_comb begin
        sum = a;
        case ({q[0], q1})
            BOOTH_ADD: sum = a + m;
            BOOTH_SUB: sum = a - m;
            BOOTH_NOP: sum = a;
            default:   sum = a;
        endcase
    end

    assign a_nxt  = {sum[N], sum[N:1]};
    assign q_nxt  = {sum[0], q[N-1:1]};
    assign q1_nxt = q[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed N x N -> 2N multiplier, one Booth step per clock.
// Latency: start at edge k gives a done pulse (with out valid) in the cycle after edge k+N+1.
// No backpressure: start is honoured only in IDLE and ignored while an operation is in flight.
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplier,
    input  logic [N-1:0]   multiplicand,
    output logic [2*N-1:0] out,
    output logic           busy,
    output logic           done
);

    localparam int CW = cnt_width(N);

    state_t        state, state_nxt;
    logic [N:0]    a_q, m_q;
    logic [N-1:0]  q_q;
    logic          q1_q;
    logic [CW-1:0] cnt_q;

    logic [N:0]    a_step;
    logic [N-1:0]  q_step;
    logic          q1_step;

    booth_step #(.N(N)) u_step (
        .a      (a_q),
        .q      (q_q),
        .q1     (q1_q),
        .m      (m_q),
        .a_nxt  (a_step),
        .q_nxt  (q_step),
        .q1_nxt (q1_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt_q == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy covers RUN, DONE and the cycle in which the done pulse is visible
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            m_q   <= '0;
            q_q   <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE) || (state == DONE);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q   <= {multiplicand[N-1], multiplicand};
                        q_q   <= multiplier;
                        q1_q  <= 1'b0;
                        a_q   <= '0;
                        cnt_q <= CW'(N);
                    end
                end
                RUN: begin
                    a_q   <= a_step;
                    q_q   <= q_step;
                    q1_q  <= q1_step;
                    cnt_q <= cnt_q - CW'(1);
                end
                DONE: begin
                    out <= {a_q[N-1:0], q_q};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier (N=4): directed cases, protocol corners, exhaustive and random sweeps.
module tb_booth_seq_multiplier;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplier;
    logic [N-1:0]   multiplicand;
    logic [2*N-1:0] out;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;

    booth_seq_multiplier #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .out          (out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Signed reference: interpret the N-bit patterns as two's complement and multiply
    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y);
        int sx, sy, p;
        sx = x[N-1] ? int'(x) - (1 << N) : int'(x);
        sy = y[N-1] ? int'(y) - (1 << N) : int'(y);
        p  = sx * sy;
        return p[2*N-1:0];
    endfunction

    // Runs one operation; optionally re-asserts start with other operands at cycle 'inject'.
    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input int inject,
                         output logic [2*N-1:0] res, output int lat, output int ndone,
                         output logic busy_mid, output logic busy_end);
        res = '0; lat = 0; ndone = 0; busy_mid = 1'b0;
        @(negedge clk);
        multiplier = x; multiplicand = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        multiplier = N'($urandom); multiplicand = N'($urandom);
        busy_mid = busy;
        for (int c = 2; c <= N + 6; c++) begin
            if (c == inject) begin
                start = 1'b1; multiplier = 4'd3; multiplicand = 4'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c;
                    res = out;
                end
            end
        end
        start = 1'b0;
        busy_end = busy;
    endtask

    typedef struct {
        logic [N-1:0]   x;
        logic [N-1:0]   y;
        logic [2*N-1:0] exp;
        string          tag;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [2*N-1:0] res, held;
        int lat, nd, cnt;
        logic bm, be;

        rst = 1'b1; start = 1'b0; multiplier = '0; multiplicand = '0;

        vecs.push_back('{4'd3, 4'd3, 8'h09, "3x3"});
        vecs.push_back('{4'd7, 4'd5, 8'h23, "7x5"});
        vecs.push_back('{4'd4, 4'd4, 8'h10, "4x4"});
        vecs.push_back('{4'd0, 4'hF, 8'h00, "0xm1"});
        vecs.push_back('{4'hF, 4'hF, 8'h01, "m1xm1"});
        vecs.push_back('{4'h9, 4'd5, 8'hDD, "m7x5"});
        vecs.push_back('{4'd7, 4'hB, 8'hDD, "7xm5"});
        vecs.push_back('{4'h9, 4'hB, 8'h23, "m7xm5"});
        vecs.push_back('{4'h8, 4'h8, 8'h40, "m8xm8"});
        vecs.push_back('{4'h8, 4'd7, 8'hC8, "m8x7"});
        vecs.push_back('{4'd7, 4'h8, 8'hC8, "7xm8"});

        // start during reset must be overridden
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        start = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].x, vecs[i].y, 0, res, lat, nd, bm, be);
            check(vecs[i].tag, 32'(res), 32'(vecs[i].exp));
            check({vecs[i].tag, "_lat"}, 32'(lat), 32'(N + 2));
            check({vecs[i].tag, "_ndone"}, 32'(nd), 32'd1);
            check({vecs[i].tag, "_busy_run"}, 32'(bm), 32'd1);
            check({vecs[i].tag, "_busy_idle"}, 32'(be), 32'd0);
        end

        // start re-asserted mid-RUN with 3x3 must be ignored
        do_op(4'd7, 4'd5, 3, res, lat, nd, bm, be);
        check("midrun_prod", 32'(res), 32'h23);
        check("midrun_ndone", 32'(nd), 32'd1);
        check("midrun_busy_end", 32'(be), 32'd0);

        // out holds between operations
        held = out;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            multiplier = N'($urandom); multiplicand = N'($urandom);
            @(negedge clk);
            if (done) nd++;
            if (out !== held) nd += 100;
        end
        check("hold_out", 32'(out), 32'h23);
        check("hold_quiet", 32'(nd), 32'd0);

        // reset during RUN aborts with no done pulse
        @(negedge clk);
        multiplier = 4'd7; multiplicand = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out", 32'(out), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        nd = 0;
        for (int c = 0; c < N + 6; c++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("abort_quiet", 32'(nd), 32'd0);
        do_op(4'd3, 4'd3, 0, res, lat, nd, bm, be);
        check("after_abort", 32'(res), 32'h09);
        check("after_abort_lat", 32'(lat), 32'(N + 2));

        // exhaustive sweep against the model
        cnt = 0;
        for (int i = 0; i < (1 << N); i++) begin
            for (int j = 0; j < (1 << N); j++) begin
                do_op(N'(i), N'(j), 0, res, lat, nd, bm, be);
                if (res !== ref_prod(N'(i), N'(j)) || lat != N + 2 || nd != 1) begin
                    cnt++;
                    check($sformatf("sweep_%0d_%0d", i, j),
                          {8'(lat), 8'(nd), 8'h0, 8'(res)},
                          {8'(N + 2), 8'd1, 8'h0, 8'(ref_prod(N'(i), N'(j)))});
                end
            end
        end
        check("sweep_errors", 32'(cnt), 32'd0);

        // random operands, also with random mid-RUN start injection
        for (int k = 0; k < 40; k++) begin
            logic [N-1:0] x, y;
            x = N'($urandom);
            y = N'($urandom);
            do_op(x, y, (k % 2 == 0) ? 0 : int'($urandom_range(2, N + 1)), res, lat, nd, bm, be);
            check($sformatf("rand%0d_prod", k), 32'(res), 32'(ref_prod(x, y)));
            check($sformatf("rand%0d_ndone", k), 32'(nd), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Sequential signed two's-complement multiplier using radix-2 Booth recoding, one Booth step per clock.
- Accepts two N-bit signed operands on a start pulse and returns the 2N-bit signed product with a done pulse.
- Used as a small-area arithmetic unit where a single-cycle array multiplier is not warranted.

Parameters:
- N, 4, operand width in bits (N >= 2); product width is 2N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a multiply; sampled only while idle.
- multiplier  input  N  signed two's-complement multiplier operand.
- multiplicand  input  N  signed two's-complement multiplicand operand.
- out  output  2N  signed product of the last completed operation.
- busy  output  1  high while an operation is in progress (RUN or DONE state).
- done  output  1  one-cycle pulse when out updates with a new product.

Behaviour:
- Reset is synchronous and active-high. On a clk edge with rst=1: state=IDLE; out=0, busy=0, done=0; all internal registers cleared. Reset overrides start and aborts any in-progress operation with no done pulse.
- States are IDLE, RUN and DONE.
- IDLE -> RUN when start=1:
  - latch M = sign-extended multiplicand to N+1 bits.
  - Q = multiplier; Q_-1 = 0; A = 0 (N+1 bits); step counter = N.
  - busy goes high on the next cycle.
- RUN performs one Booth step per cycle, decoding {Q[0], Q_-1}:
  - 01: A = A + M.
  - 10: A = A - M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {A, Q, Q_-1} by one, with A's MSB replicated.
  - Decrement the counter. After the N-th step go to DONE.
- DONE lasts one cycle:
  - out = lower 2N bits of {A, Q}; done=1; busy stays 1.
  - Next state is IDLE. done returns to 0 and busy to 0.
- Latency: start sampled at edge k -> done=1 and out valid during the cycle after edge k+N+1 (N+2 cycles start-to-start throughput).
- start while busy (RUN or DONE) is ignored. Operands may change freely after the capture edge.
- Arithmetic:
  - The (N+1)-bit accumulator makes M = -2^(N-1) (e.g. -8 for N=4) exact, including -2^(N-1) * -2^(N-1) = +2^(2N-2).
  - Add/sub wrap modulo 2^(N+1); no overflow flag.
- Inputs are always interpreted as signed. An input bit pattern 4'hF means -1, not 15.
- out holds its value between operations and changes only in DONE or on reset.
- done and busy are registered outputs.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Booth op-code constants (NOP, ADD, SUB) decoded from {Q[0], Q_-1}.
  - Counter-width function clog2(N+1).
- One combinational sub-module, booth_step:
  - Inputs: A, Q, Q_-1, M.
  - Outputs: the next shifted A, Q, Q_-1.
  - The top module holds the FSM, the counter and the registers.

Test Plan:
- Reset, then start with multiplier=3, multiplicand=3 -> done after N+1 cycles, out=8'h09. Also 7*5 -> 8'h23 and 4*4 -> 8'h10.
- Zero and the -1 pattern: 0*4'hF -> 8'h00. 4'hF*4'hF (i.e. -1*-1) -> 8'h01.
- Sign combinations: -7*5 -> 8'hDD; 7*-5 -> 8'hDD; -7*-5 -> 8'h23.
- Most-negative corners: -8*-8 -> 8'h40; -8*7 -> 8'hC8; 7*-8 -> 8'hC8.
- Protocol, in three parts:
  - Assert start again mid-RUN with different operands -> ignored, original product delivered.
  - Exactly one done pulse per operation.
  - out stable between operations.
- Reset mid-RUN (rst=1 at step 2) -> next cycle out=0, busy=0, no done pulse. A subsequent 3*3 yields 8'h09.
- Exhaustive N=4 sweep of all 256 operand pairs versus a signed reference model.
